// File: rtl/usb_reg_arbiter.sv
// Round-robin arbiter sharing the ULPI register port among NUM_REQ requesters, one access in flight, with timeout.
// Latency: req_en->reg_en 1 cycle, reg_rdy->req_rdy 1 cycle; requesters are stalled by holding req_en until their req_rdy.
module usb_reg_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_en,
   input  logic [NUM_REQ-1:0]   req_we,
   input  logic [8*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_din,
   output logic [NUM_REQ-1:0]   req_rdy,
   output logic [NUM_REQ-1:0]   req_err,
   output logic [7:0]           req_dout,
   output logic                 reg_en,
   output logic                 reg_we,
   output logic [7:0]           reg_addr,
   output logic [7:0]           reg_din,
   input  logic                 reg_rdy,
   input  logic [7:0]           reg_dout
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit TO_EN = (TIMEOUT != 0);
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [GW-1:0]      last_grant_q, last_grant_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               reg_en_q, reg_en_d;
   logic               reg_we_q, reg_we_d;
   logic [7:0]         reg_addr_q, reg_addr_d;
   logic [7:0]         reg_din_q, reg_din_d;
   logic [7:0]         req_dout_q, req_dout_d;
   logic [NUM_REQ-1:0] req_rdy_q, req_rdy_d;
   logic [NUM_REQ-1:0] req_err_q, req_err_d;

   logic               win_vld;
   logic [GW-1:0]      win_idx;
   logic [GW:0]        cand;
   logic               win_we;
   logic [7:0]         win_addr;
   logic [7:0]         win_din;

   // Walk from farthest to nearest after last_grant so the nearest requester overrides.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = {1'b0, last_grant_q} + (GW+1)'(k);
         if (cand >= (GW+1)'(NUM_REQ)) begin
            cand = cand - (GW+1)'(NUM_REQ);
         end
         if (req_en[cand[GW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = cand[GW-1:0];
         end
      end
   end

   always_comb begin
      win_we   = 1'b0;
      win_addr = '0;
      win_din  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == GW'(i)) begin
            win_we   = req_we[i];
            win_addr = req_addr[8*i +: 8];
            win_din  = req_din[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      reg_en_d     = reg_en_q;
      reg_we_d     = reg_we_q;
      reg_addr_d   = reg_addr_q;
      reg_din_d    = reg_din_q;
      req_dout_d   = req_dout_q;
      req_rdy_d    = '0;
      req_err_d    = '0;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               grant_d    = win_idx;
               reg_en_d   = 1'b1;
               reg_we_d   = win_we;
               reg_addr_d = win_addr;
               reg_din_d  = win_din;
               timer_d    = '0;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            timer_d = timer_q + TW'(1);
            // A completion on the final timeout cycle is still a normal completion.
            if (reg_rdy) begin
               reg_en_d     = 1'b0;
               req_dout_d   = reg_we_q ? 8'h00 : reg_dout;
               last_grant_d = grant_q;
               state_d      = S_HOLD;
               for (int i = 0; i < NUM_REQ; i++) begin
                  req_rdy_d[i] = (grant_q == GW'(i));
               end
            end else if (TO_EN && (timer_q == T_LAST)) begin
               reg_en_d     = 1'b0;
               req_dout_d   = 8'h00;
               last_grant_d = grant_q;
               state_d      = S_HOLD;
               for (int i = 0; i < NUM_REQ; i++) begin
                  req_rdy_d[i] = (grant_q == GW'(i));
                  req_err_d[i] = (grant_q == GW'(i));
               end
            end
         end
         S_HOLD: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
         timer_q      <= '0;
         reg_en_q     <= 1'b0;
         reg_we_q     <= 1'b0;
         reg_addr_q   <= '0;
         reg_din_q    <= '0;
         req_dout_q   <= '0;
         req_rdy_q    <= '0;
         req_err_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         reg_en_q     <= reg_en_d;
         reg_we_q     <= reg_we_d;
         reg_addr_q   <= reg_addr_d;
         reg_din_q    <= reg_din_d;
         req_dout_q   <= req_dout_d;
         req_rdy_q    <= req_rdy_d;
         req_err_q    <= req_err_d;
      end
   end

   assign reg_en   = reg_en_q;
   assign reg_we   = reg_we_q;
   assign reg_addr = reg_addr_q;
   assign reg_din  = reg_din_q;
   assign req_rdy  = req_rdy_q;
   assign req_err  = req_err_q;
   assign req_dout = req_dout_q;

endmodule

// File: tb/tb_usb_reg_arbiter.sv
// Bench for usb_reg_arbiter: directed vector table, hand sequences for timeout/reset, then random traffic vs a transaction model.
module tb_usb_reg_arbiter;

   localparam int NREQ = 3;
   localparam int TMO  = 16;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_en, req_we;
   logic [23:0] req_addr, req_din;
   logic [2:0]  req_rdy, req_err;
   logic [7:0]  req_dout;
   logic        reg_en, reg_we;
   logic [7:0]  reg_addr, reg_din;
   logic        reg_rdy;
   logic [7:0]  reg_dout;

   int vectors = 0;
   int miscompares = 0;
   int n;

   usb_reg_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_en(req_en), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
      .req_rdy(req_rdy), .req_err(req_err), .req_dout(req_dout),
      .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din),
      .reg_rdy(reg_rdy), .reg_dout(reg_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  en, we;
      logic [23:0] addr, din;
      logic        rdy;
      logic [7:0]  rdout;
      logic        x_en, x_we;
      logic [7:0]  x_addr, x_din;
      logic [2:0]  x_rdy, x_err;
      logic [7:0]  x_dout;
   } vec_t;

   vec_t tbl[$];

   task automatic v(input logic [2:0] en, input logic [2:0] we, input logic [23:0] addr,
                    input logic [23:0] din, input logic rdy, input logic [7:0] rdout,
                    input logic x_en, input logic x_we, input logic [7:0] x_addr,
                    input logic [7:0] x_din, input logic [2:0] x_rdy, input logic [2:0] x_err,
                    input logic [7:0] x_dout);
      vec_t r;
      r.en = en; r.we = we; r.addr = addr; r.din = din; r.rdy = rdy; r.rdout = rdout;
      r.x_en = x_en; r.x_we = x_we; r.x_addr = x_addr; r.x_din = x_din;
      r.x_rdy = x_rdy; r.x_err = x_err; r.x_dout = x_dout;
      tbl.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic new_fields(input int i);
      req_we[i[1:0]] = 1'($urandom_range(0, 1));
      req_addr[{i[1:0], 3'b000} +: 8] = 8'($urandom);
      req_din[{i[1:0], 3'b000} +: 8]  = 8'($urandom);
   endtask

   // Transaction-level reference: one access at a time, served round-robin, timed out after TMO cycles.
   bit         m_busy, m_tmo;
   int         m_owner, m_age, m_cool, m_last, m_c;
   logic       mdl_en, mdl_we;
   logic [7:0] mdl_addr, mdl_din, mdl_dout;
   logic [2:0] mdl_rdy, mdl_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_age = 0; m_cool = 0; m_last = NREQ - 1; m_owner = 0;
         mdl_en = 0; mdl_we = 0; mdl_addr = 0; mdl_din = 0; mdl_dout = 0;
         mdl_rdy = 0; mdl_err = 0;
      end else begin
         mdl_rdy = '0;
         mdl_err = '0;
         if (m_busy) begin
            m_age++;
            if (reg_rdy === 1'b1 || m_age == TMO) begin
               m_tmo = (reg_rdy !== 1'b1);
               mdl_rdy[m_owner[1:0]] = 1'b1;
               mdl_err[m_owner[1:0]] = m_tmo;
               mdl_dout = (m_tmo || mdl_we) ? 8'h00 : reg_dout;
               m_last = m_owner;
               m_busy = 0;
               m_cool = 1;
            end
         end else if (m_cool > 0) begin
            m_cool--;
         end else begin
            for (int k = 1; k <= NREQ; k++) begin
               m_c = (m_last + k) % NREQ;
               if (!m_busy && req_en[m_c[1:0]] === 1'b1) begin
                  m_busy = 1; m_owner = m_c; m_age = 0;
                  mdl_we = req_we[m_c[1:0]];
                  mdl_addr = 8'(req_addr >> (8 * m_c));
                  mdl_din  = 8'(req_din >> (8 * m_c));
               end
            end
         end
         mdl_en = m_busy;
      end
   end

   initial begin
      rst_n = 1'b0; req_en = '0; req_we = '0; req_addr = '0; req_din = '0;
      reg_rdy = 1'b0; reg_dout = '0;

      // single read, req0
      v(3'b001,3'b000,24'h000016,24'h0,1'b0,8'h00, 1'b1,1'b0,8'h16,8'h00,3'b000,3'b000,8'h00);
      v(3'b001,3'b000,24'h000016,24'h0,1'b0,8'h00, 1'b1,1'b0,8'h16,8'h00,3'b000,3'b000,8'h00);
      v(3'b001,3'b000,24'h000016,24'h0,1'b1,8'hA5, 1'b0,1'b0,8'h00,8'h00,3'b001,3'b000,8'hA5);
      v(3'b000,3'b000,24'h000000,24'h0,1'b0,8'h00, 1'b0,1'b0,8'h00,8'h00,3'b000,3'b000,8'hA5);
      // write, req1
      v(3'b010,3'b010,24'h000A00,24'h004000,1'b0,8'h00, 1'b1,1'b1,8'h0A,8'h40,3'b000,3'b000,8'hA5);
      v(3'b010,3'b010,24'h000A00,24'h004000,1'b0,8'h00, 1'b1,1'b1,8'h0A,8'h40,3'b000,3'b000,8'hA5);
      v(3'b010,3'b010,24'h000A00,24'h004000,1'b1,8'hFF, 1'b0,1'b0,8'h00,8'h00,3'b010,3'b000,8'h00);
      v(3'b000,3'b000,24'h000000,24'h0,1'b0,8'h00, 1'b0,1'b0,8'h00,8'h00,3'b000,3'b000,8'h00);
      // contention between req0 and req1
      v(3'b011,3'b000,24'h002120,24'h0,1'b0,8'h00, 1'b1,1'b0,8'h20,8'h00,3'b000,3'b000,8'h00);
      v(3'b011,3'b000,24'h002120,24'h0,1'b1,8'h11, 1'b0,1'b0,8'h00,8'h00,3'b001,3'b000,8'h11);
      v(3'b011,3'b000,24'h002120,24'h0,1'b0,8'h00, 1'b0,1'b0,8'h00,8'h00,3'b000,3'b000,8'h11);
      v(3'b011,3'b000,24'h002120,24'h0,1'b0,8'h00, 1'b1,1'b0,8'h21,8'h00,3'b000,3'b000,8'h11);
      v(3'b011,3'b000,24'h002120,24'h0,1'b1,8'h22, 1'b0,1'b0,8'h00,8'h00,3'b010,3'b000,8'h22);
      v(3'b011,3'b000,24'h002120,24'h0,1'b0,8'h00, 1'b0,1'b0,8'h00,8'h00,3'b000,3'b000,8'h22);
      v(3'b011,3'b000,24'h002120,24'h0,1'b0,8'h00, 1'b1,1'b0,8'h20,8'h00,3'b000,3'b000,8'h22);
      v(3'b011,3'b000,24'h002120,24'h0,1'b1,8'h33, 1'b0,1'b0,8'h00,8'h00,3'b001,3'b000,8'h33);
      v(3'b011,3'b000,24'h002120,24'h0,1'b0,8'h00, 1'b0,1'b0,8'h00,8'h00,3'b000,3'b000,8'h33);
      v(3'b011,3'b000,24'h002120,24'h0,1'b0,8'h00, 1'b1,1'b0,8'h21,8'h00,3'b000,3'b000,8'h33);
      v(3'b011,3'b000,24'h002120,24'h0,1'b1,8'h44, 1'b0,1'b0,8'h00,8'h00,3'b010,3'b000,8'h44);
      v(3'b000,3'b000,24'h000000,24'h0,1'b0,8'h00, 1'b0,1'b0,8'h00,8'h00,3'b000,3'b000,8'h44);
      // stray reg_rdy while idle
      v(3'b000,3'b000,24'h000000,24'h0,1'b1,8'h77, 1'b0,1'b0,8'h00,8'h00,3'b000,3'b000,8'h44);
      v(3'b000,3'b000,24'h000000,24'h0,1'b0,8'h00, 1'b0,1'b0,8'h00,8'h00,3'b000,3'b000,8'h44);

      repeat (2) @(negedge clk);
      chk("reset outputs", {reg_en, reg_we, reg_addr, reg_din, req_rdy, req_err, req_dout}, 32'h0);
      rst_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         req_en = tbl[k].en; req_we = tbl[k].we; req_addr = tbl[k].addr; req_din = tbl[k].din;
         reg_rdy = tbl[k].rdy; reg_dout = tbl[k].rdout;
         @(negedge clk);
         chk($sformatf("tbl[%0d] ctl", k), 32'({reg_en, req_rdy, req_err, req_dout}),
             32'({tbl[k].x_en, tbl[k].x_rdy, tbl[k].x_err, tbl[k].x_dout}));
         if (tbl[k].x_en)
            chk($sformatf("tbl[%0d] fields", k), 32'({reg_we, reg_addr, reg_din}),
                32'({tbl[k].x_we, tbl[k].x_addr, tbl[k].x_din}));
      end

      // timeout on req2: reg_en high exactly TMO cycles, then rdy+err with zero data
      req_en = 3'b100; req_we = '0; req_addr = 24'h330000; req_din = '0;
      n = 0;
      @(negedge clk);
      while (reg_en === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("timeout reg_en cycles", n, TMO);
      chk("timeout rdy/err/dout", 32'({req_rdy, req_err, req_dout}), 32'({3'b100, 3'b100, 8'h00}));
      req_en = '0;
      @(negedge clk);
      chk("timeout pulse width", 32'({req_rdy, req_err}), 32'h0);

      // completion on the last timeout cycle beats the timeout
      req_en = 3'b001; req_addr = 24'h000044;
      n = 0;
      @(negedge clk);
      while (reg_en === 1'b1 && n < TMO - 1) begin
         n++;
         @(negedge clk);
      end
      chk("last-cycle reg_en still high", 32'({reg_en, 8'(n)}), 32'({1'b1, 8'(TMO - 1)}));
      reg_rdy = 1'b1; reg_dout = 8'h5A;
      @(negedge clk);
      reg_rdy = 1'b0;
      chk("last-cycle rdy wins", 32'({reg_en, req_rdy, req_err, req_dout}), 32'({1'b0, 3'b001, 3'b000, 8'h5A}));

      // reset in the middle of an access
      req_en = 3'b010; req_addr = 24'h005500;
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset grant", 32'({reg_en, reg_addr}), 32'({1'b1, 8'h55}));
      #2 rst_n = 1'b0;
      #1 chk("async reset outputs", {reg_en, reg_we, reg_addr, reg_din, req_rdy, req_err, req_dout}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("regrant after reset", 32'({reg_en, reg_addr, req_rdy}), 32'({1'b1, 8'h55, 3'b000}));
      reg_rdy = 1'b1; reg_dout = 8'hC3;
      @(negedge clk);
      reg_rdy = 1'b0; req_en = '0;
      chk("post-reset completion", 32'({req_rdy, req_err, req_dout}), 32'({3'b010, 3'b000, 8'hC3}));

      // random traffic against the reference model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         chk($sformatf("rnd %0d ctl", cyc), 32'({reg_en, req_rdy, req_err, req_dout}),
             32'({mdl_en, mdl_rdy, mdl_err, mdl_dout}));
         if (mdl_en)
            chk($sformatf("rnd %0d fields", cyc), 32'({reg_we, reg_addr, reg_din}),
                32'({mdl_we, mdl_addr, mdl_din}));
         for (int i = 0; i < NREQ; i++) begin
            if (req_en[i[1:0]]) begin
               if (req_rdy[i[1:0]] === 1'b1) begin
                  if ($urandom_range(0, 1) == 0) req_en[i[1:0]] = 1'b0;
                  else new_fields(i);
               end else if ($urandom_range(0, 63) == 0) begin
                  req_en[i[1:0]] = 1'b0;
               end
            end else if ($urandom_range(0, 3) == 0) begin
               req_en[i[1:0]] = 1'b1;
               new_fields(i);
            end
         end
         if (reg_en === 1'b1) reg_rdy = ($urandom_range(0, 7) == 0);
         else                 reg_rdy = ($urandom_range(0, 15) == 0);
         reg_dout = 8'($urandom);
      end

      req_en = '0; reg_rdy = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
